wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter between the execution pipelines and the integer register file. It accepts completed results from integer pipeline 0, integer pipeline 1 and the load/store pipeline, and grants one source per cycle. Branch results flagged high-priority always win; the remaining sources share access fairly. The granted result is registered into a register-file write port, and the block also counts retired instructions.

## Interface
Parameters:
- INSTRET_WIDTH, 64: width of the retired-instruction counter.

Ports (the same group repeats for sources s = ip0, ip1, lsp):
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- s_wb_dst  input  5  destination register
- s_wb_result  input  64  result data
- s_wb_pc  input  64  PC of the retiring instruction
- s_wb_wb_en  input  1  register write requested
- s_wb_hipri  input  1  high-priority request (branch retirement)
- s_wb_valid  input  1  result available
- s_wb_ready  output  1  result consumed this cycle
- wb_stall  input  1  block all grants this cycle
- rf_wr_en  output  1  register-file write strobe (registered)
- rf_wr_id  output  5  register-file write index (registered)
- rf_wr_data  output  64  register-file write data (registered)
- wb_retire  output  1  one-cycle pulse per retired instruction (registered)
- wb_retire_pc  output  64  PC of the retired instruction (registered)
- wb_instret  output  INSTRET_WIDTH  retired-instruction count

## Operation
- Source indices: ip0 = 0, ip1 = 1, lsp = 2.
- Grant is combinational in the same cycle. At most one s_wb_ready is high. It is high only for the granted source, and that source's valid must be high.
- Handshake: a transfer occurs when s_wb_valid && s_wb_ready. A source holds its data while not ready. The arbiter never grants a source whose valid is low.
- Priority, evaluated in order:
  - If wb_stall = 1: no grant.
  - Otherwise, if any valid source has hipri = 1: grant the lowest-index such source.
  - Otherwise: grant a normal source using the policy selected by the configuration macro.
- rr_ptr: a 2-bit state register with values 0..2 and reset value 0.
  - It advances only on a normal (non-hipri) grant, to (granted index + 1) mod 3.
  - Value 3 is unreachable. If it is ever seen, treat it as 0.
- On a transfer from source s, the next cycle shows:
  - rf_wr_en = s_wb_wb_en && (s_wb_dst != 0)
  - rf_wr_id = s_wb_dst, rf_wr_data = s_wb_result
  - wb_retire = 1, wb_retire_pc = s_wb_pc
- Writes to x0 are suppressed: rf_wr_en = 0, but the instruction still retires.
- When no transfer occurs, the next cycle has rf_wr_en = 0 and wb_retire = 0. rf_wr_id, rf_wr_data and wb_retire_pc hold their last values.
- wb_instret increments by 1 on each transfer and wraps modulo 2^INSTRET_WIDTH.

## Timing
- Latency: a result accepted in cycle N appears on rf_wr_* and wb_retire in cycle N+1.
- Throughput: one retirement per cycle. A source that loses arbitration stalls without losing data.
- Reset: rst high at a clock edge forces the following to 0 in the next cycle:
  - rf_wr_en, rf_wr_id, rf_wr_data
  - wb_retire, wb_retire_pc
  - wb_instret, rr_ptr
- During the reset cycle all s_wb_ready = 0, so no transfer occurs. Reset asserted mid-stream drops any in-flight registered write.
- Simultaneous events:
  - Two hipri sources: the lower index wins and rr_ptr is unchanged. The other source is served the next cycle if it is still valid and hipri.
  - hipri together with wb_stall: stall wins.
- wb_instret at its maximum value plus one transfer becomes 0.

## Configuration
- Macro: WB_RR_EN.
- Defined: normal grants are round-robin. Search starts at rr_ptr, then (rr_ptr+1) mod 3, then (rr_ptr+2) mod 3; the first valid source wins. A continuously valid source waits at most 2 normal grants.
- Undefined: normal grants use fixed priority ip0 > ip1 > lsp. rr_ptr is not implemented, and all other behaviour is unchanged.

## Test plan
- After reset, all sources valid, normal priority, WB_RR_EN defined: grants occur in order ip0, ip1, lsp, ip0. rf_wr_* follows one cycle later, and wb_instret reaches 4.
- ip1 valid with hipri = 1 while ip0 and lsp are valid: ip1 is granted first and rr_ptr is unchanged. The next grant goes to the source at rr_ptr.
- ip0 retires dst = 0, wb_en = 1, result = 0x1234: next cycle rf_wr_en = 0, wb_retire = 1, wb_retire_pc = ip0 PC.
- wb_stall held for 3 cycles with lsp valid: lsp_wb_ready stays 0 and its data is held. After the stall releases, exactly one transfer carries the original result.
- INSTRET_WIDTH = 4 with 17 consecutive transfers: wb_instret reads 1 afterward.
- rst asserted in the same cycle that ip0 is valid: ip0_wb_ready = 0, and the next cycle shows rf_wr_en = 0 and wb_instret = 0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback source bundle: one completed result offered by a pipeline to the arbiter.
// The source drives the master side; the arbiter consumes the slave side and returns ready.
interface wb_arbiter_if;
    logic [4:0]  wb_dst;
    logic [63:0] wb_result;
    logic [63:0] wb_pc;
    logic        wb_wb_en;
    logic        wb_hipri;
    logic        wb_valid;
    logic        wb_ready;

    modport master (
        output wb_dst, wb_result, wb_pc, wb_wb_en, wb_hipri, wb_valid,
        input  wb_ready
    );

    modport slave (
        input  wb_dst, wb_result, wb_pc, wb_wb_en, wb_hipri, wb_valid,
        output wb_ready
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one of ip0/ip1/lsp per cycle into a registered RF write port.
// Macro WB_RR_EN selects round-robin for non-hipri grants; otherwise fixed ip0 > ip1 > lsp.
module wb_arbiter #(
    parameter int unsigned INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_arbiter_if.slave              ip0,
    wb_arbiter_if.slave              ip1,
    wb_arbiter_if.slave              lsp,
    input  logic                     wb_stall,
    output logic                     rf_wr_en,
    output logic [4:0]               rf_wr_id,
    output logic [63:0]              rf_wr_data,
    output logic                     wb_retire,
    output logic [63:0]              wb_retire_pc,
    output logic [INSTRET_WIDTH-1:0] wb_instret
);

    logic [2:0]  valid;
    logic [2:0]  hi_req;
    logic [2:0]  gnt;
    logic        xfer;
    logic [4:0]  sel_dst;
    logic [63:0] sel_result;
    logic [63:0] sel_pc;
    logic        sel_wb_en;

    assign valid  = {lsp.wb_valid, ip1.wb_valid, ip0.wb_valid};
    assign hi_req = valid & {lsp.wb_hipri, ip1.wb_hipri, ip0.wb_hipri};
    assign xfer   = |gnt;

`ifdef WB_RR_EN
    logic [1:0] rr_q;
    logic [1:0] rr_d;
    logic [1:0] rr_eff;

    // Encoding 3 is unreachable; fold it onto 0 so a corrupted pointer self-heals.
    assign rr_eff = (rr_q == 2'd3) ? 2'd0 : rr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        rr_d = rr_eff;
        if (hi_req == 3'b000) begin
            case (gnt)
                3'b001:  rr_d = 2'd1;
                3'b010:  rr_d = 2'd2;
                3'b100:  rr_d = 2'd0;
                default: rr_d = rr_eff;
            endcase
        end
    end
`endif

    always_comb begin
        gnt = 3'b000;
        if (!rst && !wb_stall) begin
            if (hi_req[0]) begin
                gnt = 3'b001;
            end else if (hi_req[1]) begin
                gnt = 3'b010;
            end else if (hi_req[2]) begin
                gnt = 3'b100;
            end else begin
`ifdef WB_RR_EN
                case (rr_eff)
                    2'd1:    gnt = valid[1] ? 3'b010 : valid[2] ? 3'b100 :
                                   valid[0] ? 3'b001 : 3'b000;
                    2'd2:    gnt = valid[2] ? 3'b100 : valid[0] ? 3'b001 :
                                   valid[1] ? 3'b010 : 3'b000;
                    default: gnt = valid[0] ? 3'b001 : valid[1] ? 3'b010 :
                                   valid[2] ? 3'b100 : 3'b000;
                endcase
`else
                gnt = valid[0] ? 3'b001 : valid[1] ? 3'b010 :
                      valid[2] ? 3'b100 : 3'b000;
`endif
            end
        end
    end

    always_comb begin
        ip0.wb_ready = gnt[0];
        ip1.wb_ready = gnt[1];
        lsp.wb_ready = gnt[2];

        sel_dst    = ip0.wb_dst;
        sel_result = ip0.wb_result;
        sel_pc     = ip0.wb_pc;
        sel_wb_en  = ip0.wb_wb_en;
        case (gnt)
            3'b010: begin
                sel_dst    = ip1.wb_dst;
                sel_result = ip1.wb_result;
                sel_pc     = ip1.wb_pc;
                sel_wb_en  = ip1.wb_wb_en;
            end
            3'b100: begin
                sel_dst    = lsp.wb_dst;
                sel_result = lsp.wb_result;
                sel_pc     = lsp.wb_pc;
                sel_wb_en  = lsp.wb_wb_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en     <= 1'b0;
            rf_wr_id     <= 5'd0;
            rf_wr_data   <= 64'd0;
            wb_retire    <= 1'b0;
            wb_retire_pc <= 64'd0;
            wb_instret   <= '0;
        end else begin
            // x0 writes are dropped but still count as a retirement.
            rf_wr_en  <= xfer && sel_wb_en && (sel_dst != 5'd0);
            wb_retire <= xfer;
            if (xfer) begin
                rf_wr_id     <= sel_dst;
                rf_wr_data   <= sel_result;
                wb_retire_pc <= sel_pc;
                wb_instret   <= wb_instret + INSTRET_WIDTH'(1);
            end
        end
    end

endmodule
